frame_scheduler: RTL and testbench

Frame sequencer in the `clk_20` LED domain. It paces frame refreshes of the color string driver (`parallel_strings`) and the white string driver (`extra_strings`). On each refresh tick it starts a color frame, but only when the pixel FIFO holds a complete frame. It then runs a pending white update, if any, and enforces an LED latch gap before the next frame. It sits between the pixel FIFO read side / `white_value_valid_20` crossing and the two string drivers, and exports counters to the regmap.

---
 rtl/frame_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// frame_scheduler: paces color/white LED string frames off a refresh tick.
// Optional busy watchdog is built when FRAME_SCHED_WATCHDOG_EN is defined.
module frame_scheduler #(
    parameter int FIFO_ADDR_WIDTH     = 13,
    parameter int FRAME_WORDS         = 8142,
    parameter int FRAME_PERIOD_CYCLES = 333333,
    parameter int LATCH_CYCLES        = 6000,
    parameter int TIMEOUT_CYCLES      = 1048575
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
    input  logic                     white_update,
    input  logic                     color_busy,
    input  logic                     white_busy,
    output logic                     color_start,
    output logic                     white_start,
    output logic                     frame_skipped,
    output logic                     watchdog_err,
    output logic [15:0]              frame_count,
    output logic [15:0]              skip_count,
    output logic                     active
);

    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;
    localparam int PER_W = $clog2(FRAME_PERIOD_CYCLES);
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
`ifdef FRAME_SCHED_WATCHDOG_EN
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES);
`else
    localparam int RUN_W = 2;
`endif

    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(FRAME_PERIOD_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_NEED = CNT_W'(FRAME_WORDS);
    localparam logic [RUN_W-1:0] HOLD_DONE  = RUN_W'(2);

    // Elaboration-time parameter sanity checks
    if (FRAME_PERIOD_CYCLES < 2) begin : g_bad_period
        $error("frame_scheduler: FRAME_PERIOD_CYCLES must be >= 2");
    end
    if (LATCH_CYCLES < 1) begin : g_bad_latch
        $error("frame_scheduler: LATCH_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
        $error("frame_scheduler: TIMEOUT_CYCLES must be >= 3");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        COLOR_RUN,
        WHITE_RUN,
        LATCH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PER_W-1:0] period_cnt;
    logic [LAT_W-1:0] latch_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             tick_pending;
    logic             white_pending;

    logic wrap;
    logic wrap_skip;
    logic fifo_ready;
    logic holdoff_done;
    logic timeout_hit;
    logic tick_take;
    logic tick_skip;
    logic skip_go;
    logic color_go;
    logic white_go;
    logic wd_fire;

    assign wrap         = enable && (period_cnt == PER_LAST);
    assign fifo_ready   = (fifo_full_count >= FRAME_NEED);
    assign holdoff_done = (run_cnt >= HOLD_DONE);
    assign wrap_skip    = wrap && tick_pending && !tick_take;
    assign skip_go      = tick_skip || wrap_skip;

`ifdef FRAME_SCHED_WATCHDOG_EN
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);
    assign timeout_hit = (run_cnt >= RUN_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and single-cycle event strobes
    always_comb begin
        state_next = state;
        tick_take  = 1'b0;
        tick_skip  = 1'b0;
        color_go   = 1'b0;
        white_go   = 1'b0;
        wd_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (tick_pending) begin
                    tick_take = 1'b1;
                    if (fifo_ready) begin
                        color_go   = 1'b1;
                        state_next = COLOR_RUN;
                    end else begin
                        tick_skip = 1'b1;
                    end
                end
            end
            COLOR_RUN: begin
                if (holdoff_done && !color_busy) begin
                    if (white_pending) begin
                        white_go   = 1'b1;
                        state_next = WHITE_RUN;
                    end else begin
                        state_next = LATCH;
                    end
                end else if (timeout_hit) begin
                    wd_fire    = 1'b1;
                    state_next = LATCH;
                end
            end
            WHITE_RUN: begin
                if (holdoff_done && !white_busy) begin
                    state_next = LATCH;
                end else if (timeout_hit) begin
                    wd_fire    = 1'b1;
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (latch_cnt == LAT_LAST) begin
                    state_next = enable ? WAIT_TICK : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Refresh period counter, held at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (!enable || wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Pending tick: a wrap re-arms it even on the cycle it is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_pending <= 1'b0;
        end else if (state_next == IDLE) begin
            tick_pending <= 1'b0;
        end else if (wrap) begin
            tick_pending <= 1'b1;
        end else if (tick_take) begin
            tick_pending <= 1'b0;
        end
    end

    // Sticky white request; a new update wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            white_pending <= 1'b0;
        end else if (white_update) begin
            white_pending <= 1'b1;
        end else if (white_go || wd_fire) begin
            white_pending <= 1'b0;
        end
    end

    // Cycles since entering the current state, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state_next != state) begin
            run_cnt <= '0;
        end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Latch gap counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_cnt <= '0;
        end else if (state == LATCH && state_next == LATCH) begin
            latch_cnt <= latch_cnt + 1'b1;
        end else begin
            latch_cnt <= '0;
        end
    end

    // Registered pulses, status and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_start   <= 1'b0;
            white_start   <= 1'b0;
            frame_skipped <= 1'b0;
            active        <= 1'b0;
            frame_count   <= 16'd0;
            skip_count    <= 16'd0;
        end else begin
            color_start   <= color_go;
            white_start   <= white_go;
            frame_skipped <= skip_go;
            active        <= (state_next != IDLE);
            if (color_go) begin
                frame_count <= frame_count + 16'd1;
            end
            if (skip_go && skip_count != 16'hFFFF) begin
                skip_count <= skip_count + 16'd1;
            end
        end
    end

`ifdef FRAME_SCHED_WATCHDOG_EN
    // Busy timeout strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            watchdog_err <= 1'b0;
        end else begin
            watchdog_err <= wd_fire;
        end
    end
`else
    assign watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed bench for frame_scheduler.
// Period 100, latch 10, timeout 50 (timeout only with FRAME_SCHED_WATCHDOG_EN).
module tb_frame_scheduler;

    localparam int FAW       = 13;
    localparam int SEL_COLOR = 0;
    localparam int SEL_WHITE = 1;
    localparam int SEL_SKIP  = 2;
    localparam int SEL_WD    = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [FAW:0]   fifo_full_count;
    logic           white_update;
    logic           color_busy;
    logic           white_busy;
    logic           color_start;
    logic           white_start;
    logic           frame_skipped;
    logic           watchdog_err;
    logic [15:0]    frame_count;
    logic [15:0]    skip_count;
    logic           active;

    int n_checks = 0;
    int n_pass   = 0;
    int color_busy_len = 20;
    int white_busy_len = 5;
    int cb_left = 0;
    int wb_left = 0;
    int n_white = 0;
    int n_wd    = 0;

    frame_scheduler #(
        .FIFO_ADDR_WIDTH     (FAW),
        .FRAME_WORDS         (8142),
        .FRAME_PERIOD_CYCLES (100),
        .LATCH_CYCLES        (10),
        .TIMEOUT_CYCLES      (50)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .fifo_full_count (fifo_full_count),
        .white_update    (white_update),
        .color_busy      (color_busy),
        .white_busy      (white_busy),
        .color_start     (color_start),
        .white_start     (white_start),
        .frame_skipped   (frame_skipped),
        .watchdog_err    (watchdog_err),
        .frame_count     (frame_count),
        .skip_count      (skip_count),
        .active          (active)
    );

    always #5 clk = ~clk;

    // String driver stand-ins: busy for a set length after each start
    always @(posedge clk) begin
        if (color_start) cb_left <= color_busy_len;
        else if (cb_left > 0) cb_left <= cb_left - 1;
        if (white_start) wb_left <= white_busy_len;
        else if (wb_left > 0) wb_left <= wb_left - 1;
        if (white_start) n_white <= n_white + 1;
        if (watchdog_err) n_wd <= n_wd + 1;
    end

    assign color_busy = (cb_left > 0);
    assign white_busy = (wb_left > 0);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            SEL_COLOR: return color_start;
            SEL_WHITE: return white_start;
            SEL_SKIP:  return frame_skipped;
            default:   return watchdog_err;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until the selected pulse is seen, or -1 when the budget expires
    task automatic wait_pulse(input int sel, input int budget, output int dt);
        dt = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (pick(sel)) begin
                dt = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int dt;
        reset           = 1'b1;
        enable          = 1'b1;
        fifo_full_count = 14'd8142;
        white_update    = 1'b0;
        step(3);

        check("rst_color_start", color_start, 0);
        check("rst_white_start", white_start, 0);
        check("rst_skipped", frame_skipped, 0);
        check("rst_watchdog", watchdog_err, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_skip_count", skip_count, 0);
        check("rst_active", active, 0);

        // Normal frames, one per period
        reset = 1'b0;
        wait_pulse(SEL_COLOR, 150, dt);
        check("first_start_latency", dt, 101);
        check("frame_count_1", frame_count, 1);
        check("active_run", active, 1);
        wait_pulse(SEL_COLOR, 150, dt);
        check("period_1_2", dt, 100);
        check("frame_count_2", frame_count, 2);
        wait_pulse(SEL_COLOR, 150, dt);
        check("period_2_3", dt, 100);
        check("frame_count_3", frame_count, 3);
        check("no_white_yet", n_white, 0);
        check("no_skips_yet", skip_count, 0);

        // White update during frame 3
        white_update = 1'b1;
        step(1);
        white_update = 1'b0;
        wait_pulse(SEL_WHITE, 50, dt);
        check("white_after_busy", dt, 21);
        wait_pulse(SEL_COLOR, 150, dt);
        check("start_after_white", dt, 78);
        check("frame_count_4", frame_count, 4);
        step(40);
        check("white_once", n_white, 1);

        // Underfilled FIFO: every tick skipped
        fifo_full_count = 14'd8141;
        wait_pulse(SEL_SKIP, 150, dt);
        check("skip_1", dt, 60);
        check("skip_count_1", skip_count, 1);
        wait_pulse(SEL_SKIP, 150, dt);
        check("skip_2", dt, 100);
        wait_pulse(SEL_SKIP, 150, dt);
        check("skip_3", dt, 100);
        check("skip_count_3", skip_count, 3);
        check("no_start_underfill", frame_count, 4);
        fifo_full_count = 14'd8142;
        wait_pulse(SEL_COLOR, 150, dt);
        check("start_at_exact_fill", dt, 100);
        check("frame_count_5", frame_count, 5);

        // Overrun: busy outlasts two wraps
        color_busy_len = 250;
        wait_pulse(SEL_SKIP, 300, dt);
        check("overrun_skip", dt, 199);
        check("skip_count_4", skip_count, 4);
        color_busy_len = 20;
        wait_pulse(SEL_COLOR, 150, dt);
        check("start_after_latch", dt, 64);
        check("frame_count_6", frame_count, 6);

        // Enable dropped mid-frame
        enable = 1'b0;
        step(40);
        check("idle_after_disable", active, 0);
        step(150);
        check("no_start_disabled", frame_count, 6);
        enable = 1'b1;
        wait_pulse(SEL_COLOR, 150, dt);
        check("restart_latency", dt, 101);
        check("frame_count_7", frame_count, 7);

        // Async reset in the middle of a color frame
        step(5);
        check("active_before_rst", active, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_active", active, 0);
        check("async_rst_frame_count", frame_count, 0);
        check("async_rst_color_start", color_start, 0);
        step(1);
        reset = 1'b0;

`ifdef FRAME_SCHED_WATCHDOG_EN
        color_busy_len = 1000;
        wait_pulse(SEL_COLOR, 150, dt);
        check("wd_start_latency", dt, 101);
        wait_pulse(SEL_WD, 100, dt);
        check("wd_timeout", dt, 50);
        check("wd_busy_still_high", color_busy, 1);
`else
        step(120);
        check("no_watchdog", n_wd, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
